mbs_arbiter: RTL

Sequencer and two-port round-robin arbiter for the 8-bit shift-add multiplier (mbs). Two requesters each submit an operand pair with a valid/ready handshake. The block grants one requester and drives the multiplier's start and operand inputs through the load/iterate sequence. It then captures the 16-bit product and returns it on the granted requester's response channel. It sits between client logic and a single shared mbs instance.

---
 rtl/mbs_arbiter_if.sv | 15 +
 rtl/mbs_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mbs_arbiter_if.sv
// Requester-side channel of the mbs arbiter: an operand-pair request plus the product response.
interface mbs_arbiter_if #(
    parameter int WIDTH = 8
);
    logic               valid;
    logic               ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] produto;

    modport master (output valid, a, b, rsp_ready, input ready, rsp_valid, produto);
    modport slave  (input valid, a, b, rsp_ready, output ready, rsp_valid, produto);
endinterface

// File: rtl/mbs_arbiter.sv
// Two-port round-robin arbiter and load/iterate/capture sequencer for one shared
// shift-add multiplier (mbs).
module mbs_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    mbs_arbiter_if.slave       req0,
    mbs_arbiter_if.slave       req1,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_multiplicando,
    output logic [WIDTH-1:0]   mult_multiplicador,
    input  logic [2*WIDTH-1:0] mult_produto,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] result0;
    logic [2*WIDTH-1:0] result1;
    logic               grant_id;
    logic               last_grant;
    logic               winner;
    logic               accept;
    logic               rsp_take;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    always_comb begin
        if (req0.valid && req1.valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1.valid;
        end
    end

    assign accept   = reset_n && (state == IDLE) && (req0.valid || req1.valid);
    assign rsp_take = grant_id ? req1.rsp_ready : req0.rsp_ready;

    assign req0.ready     = accept && !winner;
    assign req1.ready     = accept && winner;
    assign req0.rsp_valid = (state == RESP) && !grant_id;
    assign req1.rsp_valid = (state == RESP) && grant_id;
    assign req0.produto   = result0;
    assign req1.produto   = result1;

    assign mult_multiplicando = op_a;
    assign mult_multiplicador = op_b;
    assign busy               = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mult_start = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                mult_start = 1'b1;
                if (count == LAST_ITER) begin
                    state_next = CAPT;
                end
            end
            CAPT: state_next = RESP;
            RESP: begin
                if (rsp_take) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The multiplier still shows the finished product during CAPT, so it is sampled there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result0    <= '0;
            result1    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                op_a       <= winner ? req1.a : req0.a;
                op_b       <= winner ? req1.b : req0.b;
                grant_id   <= winner;
                last_grant <= winner;
            end
            if (state == LOAD) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + CNT_W'(1);
            end
            if (state == CAPT) begin
                if (grant_id) begin
                    result1 <= mult_produto;
                end else begin
                    result0 <= mult_produto;
                end
            end
        end
    end
endmodule
